branch_resolver: RTL



---
 rtl/branch_pkg.sv | 36 +++
 rtl/br_queue.sv | 74 +++++++
 rtl/branch_resolver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types and constants for the execute-side branch
//               resolver: queue entry layout, FSM states and feedback codes.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Reference PC width for the entry struct (the resolver packs entries
    // generically so other ADDR_WIDTH values use the same bit layout).
    localparam int BR_PC_WIDTH = 32;

    // One in-flight conditional branch: prediction and the not-taken-by-fetch PC
    typedef struct packed {
        logic                   pred_taken;
        logic [BR_PC_WIDTH-1:0] fallback_pc;
    } br_entry_t;

    // Resolver operating state
    typedef enum logic [0:0] {
        BR_RUN   = 1'b0,
        BR_FLUSH = 1'b1
    } br_state_t;

    // Predictor feedback qualifier encodings
    localparam logic [1:0] BR_COND_IDLE   = 2'b00;
    localparam logic [1:0] BR_COND_UPDATE = 2'b01;

    // A prediction is wrong when the actual outcome differs from it
    function automatic logic br_is_mispredict(input logic actual, input logic predicted);
        return actual ^ predicted;
    endfunction

endpackage : branch_pkg
`default_nettype wire

// File: rtl/br_queue.sv
`default_nettype none
// ============================================================================
// Module      : br_queue
// Description : Circular in-order FIFO of branch records with push, pop and
//               clear. Clear discards contents by snapping the read pointer
//               onto the write pointer and has priority over push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module br_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  wire logic                       clk,
    input  wire logic                       rst_h,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_push_data,
    input  wire logic                       i_pop,
    input  wire logic                       i_clear,
    output logic      [WIDTH-1:0]           o_head_data,
    output logic      [$clog2(DEPTH+1)-1:0] o_count
);
    import branch_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Self-protect against overflow/underflow; clear suppresses both
    always_comb begin
        w_push = i_push && !i_clear && (r_count < c_DEPTH);
        w_pop  = i_pop  && !i_clear && (r_count != '0);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (rst_h) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule : br_queue
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolver
// Description : Holds predictions of in-flight conditional branches, checks
//               them against execute outcomes, feeds the predictor and issues
//               redirect + flush on a mispredict.
//               Optional: define BR_RESOLVER_STATS_EN to add saturating
//               resolve / mispredict statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver #(
    parameter int DEPTH        = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst_h,
    input  wire logic                       push_valid,
    input  wire logic                       push_pred_taken,
    input  wire logic [ADDR_WIDTH-1:0]      push_fallback_pc,
    output logic                            push_ready,
    input  wire logic                       res_valid,
    input  wire logic                       res_taken,
    output logic                            act_taken,
    output logic                            pred_taken,
    output logic [1:0]                      branch_cond,
    output logic                            redirect_valid,
    output logic [ADDR_WIDTH-1:0]           redirect_pc,
    output logic                            flush,
    output logic [$clog2(DEPTH+1)-1:0]      inflight_count,
    output logic                            res_error
`ifdef BR_RESOLVER_STATS_EN
    ,
    output logic [15:0]                     stat_resolved,
    output logic [15:0]                     stat_mispredict
`endif
);
    import branch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int FC_W  = $clog2(FLUSH_CYCLES+1);
    localparam int ENT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] c_DEPTH      = CNT_W'(DEPTH);
    localparam logic [FC_W-1:0]  c_FLUSH_LOAD = FC_W'(FLUSH_CYCLES-1);
    localparam logic [FC_W-1:0]  c_FC_ONE     = FC_W'(1);

    br_state_t              r_state;
    logic [FC_W-1:0]        r_flush_cnt;
    logic                   r_act_taken;
    logic                   r_pred_taken;
    logic [1:0]             r_branch_cond;
    logic                   r_redirect_valid;
    logic [ADDR_WIDTH-1:0]  r_redirect_pc;
    logic                   r_flush;
    logic                   r_res_error;

    logic [ENT_W-1:0]       w_head;
    logic [CNT_W-1:0]       w_count;
    logic                   w_head_pred;
    logic [ADDR_WIDTH-1:0]  w_head_pc;
    logic                   w_push_ready;
    logic                   w_push_fire;
    logic                   w_resolve;
    logic                   w_mispredict;
    logic                   w_q_push;
    logic                   w_q_pop;

    // Entry layout: {pred_taken, fallback_pc}, same ordering as br_entry_t
    always_comb begin
        w_head_pred  = w_head[ADDR_WIDTH];
        w_head_pc    = w_head[ADDR_WIDTH-1:0];
        w_push_ready = (r_state == BR_RUN) && (w_count < c_DEPTH);
        w_push_fire  = push_valid && w_push_ready;
        w_resolve    = (r_state == BR_RUN) && res_valid && (w_count != '0);
        w_mispredict = w_resolve && br_is_mispredict(res_taken, w_head_pred);
        // A mispredict squashes the wrong-path push landing in the same cycle
        w_q_push     = w_push_fire && !w_mispredict;
        w_q_pop      = w_resolve && !w_mispredict;
    end

    br_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_queue (
        .clk         (clk),
        .rst_h       (rst_h),
        .i_push      (w_q_push),
        .i_push_data ({push_pred_taken, push_fallback_pc}),
        .i_pop       (w_q_pop),
        .i_clear     (w_mispredict),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    // Resolver FSM with registered feedback, redirect and flush outputs
    always_ff @(posedge clk) begin
        if (rst_h) begin
            r_state          <= BR_RUN;
            r_flush_cnt      <= '0;
            r_act_taken      <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_branch_cond    <= BR_COND_IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_res_error      <= 1'b0;
        end else begin
            r_branch_cond    <= BR_COND_IDLE;
            r_redirect_valid <= 1'b0;
            r_res_error      <= 1'b0;
            case (r_state)
                BR_RUN: begin
                    if (w_resolve) begin
                        r_act_taken   <= res_taken;
                        r_pred_taken  <= w_head_pred;
                        r_branch_cond <= BR_COND_UPDATE;
                        if (w_mispredict) begin
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= w_head_pc;
                            r_flush          <= 1'b1;
                            r_flush_cnt      <= c_FLUSH_LOAD;
                            r_state          <= BR_FLUSH;
                        end
                    end else if (res_valid) begin
                        // Resolve with nothing in flight
                        r_res_error <= 1'b1;
                    end
                end
                BR_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_flush <= 1'b0;
                        r_state <= BR_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - c_FC_ONE;
                    end
                end
                default: begin
                    r_flush <= 1'b0;
                    r_state <= BR_RUN;
                end
            endcase
        end
    end

`ifdef BR_RESOLVER_STATS_EN
    logic [15:0] r_stat_resolved;
    logic [15:0] r_stat_mispredict;

    // Saturating resolve / mispredict event counters
    always_ff @(posedge clk) begin
        if (rst_h) begin
            r_stat_resolved   <= '0;
            r_stat_mispredict <= '0;
        end else begin
            if (w_resolve && (r_stat_resolved != 16'hFFFF))
                r_stat_resolved <= r_stat_resolved + 16'd1;
            if (w_mispredict && (r_stat_mispredict != 16'hFFFF))
                r_stat_mispredict <= r_stat_mispredict + 16'd1;
        end
    end

    assign stat_resolved   = r_stat_resolved;
    assign stat_mispredict = r_stat_mispredict;
`endif

    assign push_ready     = w_push_ready;
    assign act_taken      = r_act_taken;
    assign pred_taken     = r_pred_taken;
    assign branch_cond    = r_branch_cond;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign inflight_count = w_count;
    assign res_error      = r_res_error;

endmodule : branch_resolver
`default_nettype wire
